// File: rtl/radar_pkg.sv
// Shared types and constants for the radar sweep controller.
// States, LED geometry and the one-step position advance rule.
package radar_pkg;

  localparam int LED_N = 8;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(LED_N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             dn;
  } step_t;

  // Bounce turns around at the ends, so 7 goes to 6 and 0 goes to 1.
  function automatic step_t radar_adv(
    input logic [IDX_W-1:0] idx,
    input logic             dn,
    input logic             wrap
  );
    step_t s;
    s.idx = idx + 1'b1;
    s.dn  = dn;
    if (wrap) begin
      s.dn = 1'b0;
    end else if (!dn && idx == IDX_MAX) begin
      s.idx = IDX_MAX - 1'b1;
      s.dn  = 1'b1;
    end else if (!dn) begin
      s.dn = 1'b0;
    end else if (idx == '0) begin
      s.idx = IDX_W'(1);
      s.dn  = 1'b0;
    end else begin
      s.idx = idx - 1'b1;
      s.dn  = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/radar_tick_div.sv
// Step divider: free-running 0..STEP_DIV-1 counter with a tick on the
// last count; clr holds it at zero.
module radar_tick_div #(
  parameter int STEP_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/radar_sweep_ctrl.sv
// Radar LED sweep controller: sweeps an LED index, dwells on targets.
// Define RADAR_HOLD_BLINK_EN to blink the LED while dwelling.
module radar_sweep_ctrl
  import radar_pkg::*;
#(
  parameter int STEP_DIV   = 25_000_000,
  parameter int HOLD_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             wrap_mode,
  input  logic             target_valid,
  input  logic [IDX_W-1:0] target_pos,
  output logic [IDX_W-1:0] led_idx,
  output logic             led_en,
  output logic             busy,
  output logic             hit,
  output logic             lap
);

  localparam int HW = $clog2(HOLD_TICKS + 1);

  state_t        state;
  logic          dir_dn;
  logic          wrap_q;
  logic [HW-1:0] hold_cnt;
  logic          tick;
  logic          clr;
  step_t         nx;

  assign clr  = (state == S_IDLE) || stop;
  assign busy = (state != S_IDLE);

  always_comb begin
    nx = radar_adv(led_idx, dir_dn, wrap_q);
  end

  radar_tick_div #(
    .STEP_DIV(STEP_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      led_idx  <= '0;
      led_en   <= 1'b0;
      dir_dn   <= 1'b0;
      wrap_q   <= 1'b0;
      hold_cnt <= '0;
      hit      <= 1'b0;
      lap      <= 1'b0;
    end else begin
      hit <= 1'b0;
      lap <= 1'b0;
      if (stop) begin
        state    <= S_IDLE;
        led_idx  <= '0;
        led_en   <= 1'b0;
        dir_dn   <= 1'b0;
        hold_cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state   <= S_SWEEP;
              led_idx <= '0;
              dir_dn  <= 1'b0;
              wrap_q  <= wrap_mode;
              led_en  <= 1'b1;
            end
          end
          S_SWEEP: begin
            if (tick) begin
              if (target_valid && led_idx == target_pos) begin
                state    <= S_HOLD;
                hold_cnt <= HW'(HOLD_TICKS);
                hit      <= 1'b1;
                led_en   <= 1'b1;
              end else begin
                led_idx <= nx.idx;
                dir_dn  <= nx.dn;
                lap     <= (nx.idx == '0);
              end
            end
          end
          S_HOLD: begin
            if (tick) begin
              hold_cnt <= hold_cnt - 1'b1;
              if (hold_cnt == HW'(1)) begin
                state   <= S_SWEEP;
                led_idx <= nx.idx;
                dir_dn  <= nx.dn;
                lap     <= (nx.idx == '0);
                led_en  <= 1'b1;
              end else begin
`ifdef RADAR_HOLD_BLINK_EN
                led_en <= ~led_en;
`else
                led_en <= 1'b1;
`endif
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/radar_sweep_ctrl.md
RADAR_SWEEP_CTRL -- requirements
Module: radar_sweep_ctrl

Interface
REQ-001 SHALL have parameter STEP_DIV, default 25_000_000, meaning clk cycles per sweep step (legal range >=1).
REQ-002 SHALL have parameter HOLD_TICKS, default 4, meaning steps dwelt on a target hit (legal range >=1).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning the reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, meaning begin sweep, honoured only in IDLE.
REQ-006 SHALL have port stop, input, 1, meaning abort to IDLE from any state.
REQ-007 SHALL have port wrap_mode, input, 1, meaning 1 = wrap 7->0, 0 = bounce 0..7..0; sampled only on accepted start.
REQ-008 SHALL have port target_valid, input, 1, meaning target_pos is meaningful.
REQ-009 SHALL have port target_pos, input, 3, meaning target LED index.
REQ-010 SHALL have port led_idx, output, 3, meaning index to the active-low LED decoder.
REQ-011 SHALL have port led_en, output, 1, meaning decoder enable; 0 = all LEDs off.
REQ-012 SHALL have port busy, output, 1, meaning state != IDLE.
REQ-013 SHALL have port hit, output, 1, meaning one-cycle pulse on entering HOLD.
REQ-014 SHALL have port lap, output, 1, meaning one-cycle pulse when the position returns to 0 from a step.

Function
REQ-015 SHALL implement states IDLE, SWEEP, HOLD.
REQ-016 SHALL run a step counter 0..STEP_DIV-1 in SWEEP/HOLD; tick = (count == STEP_DIV-1), then count wraps to 0; count held 0 in IDLE; STEP_DIV=1 gives a tick every cycle.
REQ-017 SHALL, on start in IDLE with stop low: next cycle SWEEP, led_idx=0, dir=up, count=0, wrap_mode latched.
REQ-018 SHALL, on stop in any state: next cycle IDLE, led_idx=0, led_en=0, count=0; stop wins over simultaneous start, tick or hit.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL, on a SWEEP tick with target_valid=1 and led_idx==target_pos: enter HOLD without moving, pulse hit the following cycle, load hold counter with HOLD_TICKS.
REQ-021 SHALL otherwise, on a SWEEP tick, advance: wrap mode idx+1 mod 8; bounce mode up until 7 then dir=down and idx=6, down until 0 then dir=up and idx=1.
REQ-022 SHALL, in HOLD, decrement the hold counter per tick; on the tick taking it to 0, return to SWEEP and advance per REQ-021 on that same tick (no re-hit at the same index).
REQ-023 SHALL pulse lap for one cycle whenever an advance sets led_idx to 0 (wrap 7->0, or bounce reaching 0).
REQ-024 SHALL drive led_en=1 throughout SWEEP and HOLD (subject to REQ-028).
REQ-025 SHALL register all outputs; led_idx change visible the cycle after the causing tick.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, force IDLE, led_idx=0, dir=up, count=0, hold counter=0, led_en=0, busy=0, hit=0, lap=0; rst overrides start/stop.

Configuration
REQ-027 SHALL use macro RADAR_HOLD_BLINK_EN.
REQ-028 SHALL, with RADAR_HOLD_BLINK_EN defined, toggle led_en on every tick in HOLD, starting at 1 on HOLD entry; led_en=1 on return to SWEEP. Without it, led_en stays steady 1 in HOLD.

Structure
REQ-029 SHALL place the state enum, LED_N=8 and IDX_W=3 in shared package radar_pkg.
REQ-030 SHALL implement the step counter/tick as sub-module radar_tick_div (parameter STEP_DIV, ports clk, rst, clr, tick).

Verification (STEP_DIV=4, HOLD_TICKS=3 unless noted)
REQ-031 SHALL cover: rst mid-SWEEP at idx=5 -> next cycle idx=0, led_en=0, busy=0; start ignored during rst.
REQ-032 SHALL cover: wrap_mode=1, start, no target -> idx steps 0,1..7,0 every 4 cycles; lap pulses once at 7->0.
REQ-033 SHALL cover: wrap_mode=0 -> idx sequence 0..7,6..0,1; lap at arrival at 0; no lap at 7.
REQ-034 SHALL cover: target_valid=1, target_pos=3 -> hit at idx 3, idx held 3 for 12 cycles, then idx=4; no second hit until the next pass.
REQ-035 SHALL cover: stop and start asserted together in SWEEP -> IDLE; start alone in SWEEP -> ignored, sequence unchanged.
REQ-036 SHALL cover: RADAR_HOLD_BLINK_EN defined, hit at idx 2 -> led_en 1,0,1 over the three hold ticks, then 1 in SWEEP; undefined -> led_en constant 1.
